// File: rtl/adder_accumulator_pkg.sv
// Shared types and default sizing for the burst adder/accumulator.
package adder_accumulator_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/adder_accumulator_adder.sv
// WIDTH-bit ripple-carry adder with carry-out, used as the accumulator datapath.
module AdderRippleCarry #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[WIDTH];

endmodule

// File: rtl/adder_accumulator.sv
// Accumulates a burst of operands (closed by in_last) and presents the sum,
// sticky overflow and saturating operand count until the consumer takes it.
module adder_accumulator
  import adder_accumulator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic             ovf, ovf_next;
  logic [CNT_W-1:0] count, count_next;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             ready_en;
  logic             in_fire;
  logic             out_fire;

  AdderRippleCarry #(.WIDTH(WIDTH)) u_adder (
    .a         (acc),
    .b         (in_data),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  // ready_en keeps in_ready low during reset and until the first edge after it.
  assign in_ready  = ready_en && (state != DONE);
  assign out_valid = (state == DONE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Result fields are zero whenever no result is being offered.
  assign out_sum   = out_valid ? acc   : '0;
  assign out_ovf   = out_valid ? ovf   : 1'b0;
  assign out_count = out_valid ? count : '0;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode: advance only on handshakes, otherwise hold.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a missed branch would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (in_fire) state_next = in_last ? DONE : ACCUM;
      ACCUM:   if (in_fire && in_last) state_next = DONE;
      DONE:    if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath next values: load on the first operand, add afterwards, clear on output.
  always_comb begin
    acc_next   = acc;
    ovf_next   = ovf;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (in_fire) begin
          acc_next   = in_data;
          ovf_next   = 1'b0;
          count_next = CNT_ONE;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_next   = add_sum;
          ovf_next   = ovf | add_carry;
          count_next = (count == CNT_MAX) ? count : count + CNT_ONE;
        end
      end
      DONE: begin
        if (out_fire) begin
          acc_next   = '0;
          ovf_next   = 1'b0;
          count_next = '0;
        end
      end
      default: begin
        acc_next   = '0;
        ovf_next   = 1'b0;
        count_next = '0;
      end
    endcase
  end

  // Datapath and input-enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      acc      <= acc_next;
      ovf      <= ovf_next;
      count    <= count_next;
      ready_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench: a sum-of-burst reference model checked every cycle,
// plus directed bursts with literal expectations.
module tb_adder_accumulator;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam longint MOD = 16;
  localparam int CMAX = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_count;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model: unbounded integer burst total and operand count.
  bit     m_ready_en;
  bit     m_pending;
  bit     m_accepted;
  int     m_n;
  longint m_total;

  adder_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: the sum modulo 2^WIDTH, overflow iff the true total
  // reached 2^WIDTH, count is the operand tally capped at 255.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready_en = 0;
      m_pending  = 0;
      m_accepted = 0;
      m_n        = 0;
      m_total    = 0;
    end else begin
      m_accepted = 0;
      if (!m_ready_en) begin
        m_ready_en = 1;
      end else if (m_pending) begin
        if (out_ready) begin
          m_pending = 0;
          m_n       = 0;
          m_total   = 0;
        end
      end else if (in_valid) begin
        m_accepted = 1;
        m_n++;
        m_total += longint'(in_data);
        m_pending = in_last;
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("in_ready",  in_ready,  (m_ready_en && !m_pending) ? 1 : 0);
    check("out_valid", out_valid, m_pending ? 1 : 0);
    check("out_sum",   out_sum,   m_pending ? (m_total % MOD) : 0);
    check("out_ovf",   out_ovf,   (m_pending && m_total >= MOD) ? 1 : 0);
    check("out_count", out_count, m_pending ? ((m_n > CMAX) ? CMAX : m_n) : 0);
  end

  // Present one operand; called and returns at posedge+2.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    guard    = 0;
    do begin
      @(posedge clk);
      #2;
      guard++;
    end while (!m_accepted && guard < 50);
    if (!m_accepted) check("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  // Accept the pending result with a one-cycle out_ready pulse.
  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", in_ready, 0);
    @(posedge clk);
    #2;
    check("ready_after_edge", in_ready, 1);

    // 3 + 5 + 7 = 15, no carry.
    send(3, 0); send(5, 0); send(7, 1);
    check("b1_valid", out_valid, 1);
    check("b1_sum", out_sum, 15);
    check("b1_ovf", out_ovf, 0);
    check("b1_count", out_count, 3);
    take();

    // 15 + 1 wraps to 0 with carry.
    send(15, 0); send(1, 1);
    check("b2_sum", out_sum, 0);
    check("b2_ovf", out_ovf, 1);
    check("b2_count", out_count, 2);
    take();

    // Single-operand burst.
    send(9, 1);
    check("b3_sum", out_sum, 9);
    check("b3_ovf", out_ovf, 0);
    check("b3_count", out_count, 1);
    take();

    // Back-pressure: result held, inputs blocked, extra in_valid ignored.
    send(2, 0); send(2, 1);
    in_valid = 1'b1;
    in_data  = 4'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_sum", out_sum, 4);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    take();
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);

    // Mid-burst reset discards the partial burst.
    send(6, 0); send(6, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_sum", out_sum, 0);
    check("mid_rst_count", out_count, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    send(4, 0); send(4, 1);
    check("b5_sum", out_sum, 8);
    check("b5_count", out_count, 2);
    take();

    // Count saturation over 300 zero operands.
    for (int i = 0; i < 300; i++) send(0, (i == 299));
    check("sat_count", out_count, 255);
    check("sat_sum", out_sum, 0);
    check("sat_ovf", out_ovf, 0);
    take();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #2;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    out_ready = 1'b0;
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand and sum width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: operand-count width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: operand present.
REQ-007 Port in_ready, output, 1: block accepts operand.
REQ-008 Port in_data, input, WIDTH: operand.
REQ-009 Port in_last, input, 1: operand closes the current burst.
REQ-010 Port out_valid, output, 1: result present.
REQ-011 Port out_ready, input, 1: consumer accepts result.
REQ-012 Port out_sum, output, WIDTH: burst sum modulo 2^WIDTH.
REQ-013 Port out_ovf, output, 1: sticky; set if any addition in the burst produced carry-out.
REQ-014 Port out_count, output, CNT_W: operands accepted in the burst.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-016 Input handshake SHALL be in_valid and in_ready high on the same rising edge; output handshake SHALL be out_valid and out_ready high on the same rising edge.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE; in_valid in DONE SHALL be ignored.
REQ-018 IDLE handshake SHALL set acc to in_data, ovf to 0 and count to 1. The next state SHALL be DONE if in_last is 1, otherwise ACCUM.
REQ-019 ACCUM handshake SHALL set acc to (acc + in_data) mod 2^WIDTH, OR the adder carry-out into ovf, and increment count. The next state SHALL be DONE if in_last is 1.
REQ-020 count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 Without a handshake, acc, ovf, count and state SHALL hold.
REQ-022 out_valid SHALL be 1 only in DONE. It SHALL rise on the first cycle after the in_last handshake, giving a latency of 1 cycle.
REQ-023 In DONE, out_sum, out_ovf and out_count SHALL equal acc, ovf and count, and SHALL stay stable until the output handshake.
REQ-024 The DONE output handshake SHALL return the FSM to IDLE and clear acc, ovf and count on the same edge.
REQ-025 A single-operand burst (in_last on the first operand) SHALL produce out_sum = in_data, out_ovf = 0 and out_count = 1.
REQ-026 out_sum, out_ovf and out_count SHALL read 0 whenever out_valid is 0.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, acc 0, ovf 0, count 0, out_valid 0 and in_ready 0.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-029 Reset in mid-burst SHALL discard the partial burst, with no result emitted.

Structure
REQ-030 A shared package SHALL hold the FSM state enum {IDLE, ACCUM, DONE} and the default WIDTH and CNT_W constants.
REQ-031 The combinational addition SHALL be one instance of sub-module AdderRippleCarry, WIDTH bits, with inputs acc and in_data and outputs sum and carry-out.
REQ-032 All state SHALL be registered in this module, with no latches.

Verification (WIDTH=4, CNT_W=8)
REQ-033 Operands 3, 5, 7 (last) SHALL give, one cycle later, out_valid=1, out_sum=15, out_ovf=0, out_count=3.
REQ-034 Operands 15, 1 (last) SHALL give out_sum=0, out_ovf=1, out_count=2.
REQ-035 Operand 9 with in_last SHALL give out_sum=9, out_ovf=0, out_count=1.
REQ-036 Operands 2, 2 (last) with out_ready held low for 5 cycles:
- outputs SHALL stay at out_sum=4 and in_ready SHALL stay 0;
- with out_ready high, IDLE and in_ready=1 SHALL follow on the next cycle.
REQ-037 rst_n pulsed low after operands 6, 6 SHALL force all outputs to 0 with no result; a following burst 4, 4 (last) SHALL give out_sum=8, out_count=2.
REQ-038 300 zero operands, the last with in_last, SHALL give out_count=255, out_sum=0, out_ovf=0.
